// File: rtl/commit_unit.sv
// commit_unit: in-order ROB-head retirement with register writes, store handshake and exception flush
module commit_unit #(
    parameter int BITWIDTH = 32,
    parameter logic [BITWIDTH-1:0] EXC_VECTOR = BITWIDTH'(32'h0000_0100)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                head_valid,
    input  logic                head_done,
    input  logic [BITWIDTH-1:0] head_dest_id,
    input  logic [BITWIDTH-1:0] head_dest_val,
    input  logic [BITWIDTH-1:0] head_pc,
    input  logic                head_is_store,
    input  logic [BITWIDTH-1:0] head_store_addr,
    input  logic [BITWIDTH-1:0] head_store_data,
    input  logic                head_exception,
    output logic                head_pop,
    output logic                rf_we,
    output logic [BITWIDTH-1:0] rf_waddr,
    output logic [BITWIDTH-1:0] rf_wdata,
    output logic                st_valid,
    output logic [BITWIDTH-1:0] st_addr,
    output logic [BITWIDTH-1:0] st_data,
    input  logic                st_ready,
    output logic                flush,
    output logic [BITWIDTH-1:0] redirect_pc,
    output logic [BITWIDTH-1:0] epc,
    output logic [BITWIDTH-1:0] retired_count
);
    typedef enum logic [1:0] {RUN, STORE_WAIT, FLUSH} state_t;
    state_t state;
    logic   ready_head;
    assign ready_head = head_valid && head_done;
    // ALU heads retire immediately; stores retire on the memory handshake; exceptions never pop
    assign head_pop = !rst && ((state == RUN && ready_head && !head_exception && !head_is_store) ||
                               (state == STORE_WAIT && st_ready));
    // retirement FSM with registered commit outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            rf_we         <= 1'b0;
            rf_waddr      <= '0;
            rf_wdata      <= '0;
            st_valid      <= 1'b0;
            st_addr       <= '0;
            st_data       <= '0;
            flush         <= 1'b0;
            redirect_pc   <= '0;
            epc           <= '0;
            retired_count <= '0;
        end else begin
            rf_we         <= 1'b0;
            flush         <= 1'b0;
            retired_count <= retired_count + BITWIDTH'(head_pop);
            case (state)
                RUN: begin
                    if (ready_head && head_exception) begin
                        epc         <= head_pc;
                        redirect_pc <= EXC_VECTOR;
                        flush       <= 1'b1;
                        state       <= FLUSH;
                    end else if (ready_head && head_is_store) begin
                        st_valid <= 1'b1;
                        st_addr  <= head_store_addr;
                        st_data  <= head_store_data;
                        state    <= STORE_WAIT;
                    end else if (ready_head) begin
                        rf_we    <= head_dest_id != '0;
                        rf_waddr <= head_dest_id;
                        rf_wdata <= head_dest_val;
                    end
                end
                STORE_WAIT: begin
                    if (st_ready) begin
                        st_valid <= 1'b0;
                        state    <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_commit_unit.sv
// tb_commit_unit: vector table plus hand sequences, scoreboarded register writes and stores
module tb_commit_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        head_valid, head_done, head_is_store, head_exception, st_ready;
    logic [31:0] head_dest_id, head_dest_val, head_pc, head_store_addr, head_store_data;
    logic        head_pop, rf_we, st_valid, flush;
    logic [31:0] rf_waddr, rf_wdata, st_addr, st_data, redirect_pc, epc, retired_count;
    logic        w_valid;
    logic [3:0]  z4;
    logic        pop4, we4, stv4, fl4;
    logic [3:0]  wa4, wd4, sa4, sd4, rp4, ep4, cnt4;
    int          pass_cnt = 0;
    int          total = 0;
    int          exp_cnt = 0;
    logic [63:0] rf_q[$];
    logic [63:0] st_q[$];
    logic [63:0] e;

    always #5 clk = ~clk;

    commit_unit dut (
        .clk(clk), .rst(rst), .head_valid(head_valid), .head_done(head_done),
        .head_dest_id(head_dest_id), .head_dest_val(head_dest_val), .head_pc(head_pc),
        .head_is_store(head_is_store), .head_store_addr(head_store_addr),
        .head_store_data(head_store_data), .head_exception(head_exception),
        .head_pop(head_pop), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .flush(flush), .redirect_pc(redirect_pc), .epc(epc), .retired_count(retired_count)
    );

    commit_unit #(.BITWIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .head_valid(w_valid), .head_done(1'b1),
        .head_dest_id(z4), .head_dest_val(z4), .head_pc(z4),
        .head_is_store(1'b0), .head_store_addr(z4), .head_store_data(z4),
        .head_exception(1'b0), .head_pop(pop4), .rf_we(we4), .rf_waddr(wa4), .rf_wdata(wd4),
        .st_valid(stv4), .st_addr(sa4), .st_data(sd4), .st_ready(1'b0),
        .flush(fl4), .redirect_pc(rp4), .epc(ep4), .retired_count(cnt4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_head(input logic v, input logic d, input logic st, input logic ex,
                            input logic [31:0] id, input logic [31:0] val, input logic [31:0] pc,
                            input logic [31:0] addr, input logic [31:0] data);
        head_valid = v; head_done = d; head_is_store = st; head_exception = ex;
        head_dest_id = id; head_dest_val = val; head_pc = pc;
        head_store_addr = addr; head_store_data = data;
    endtask

    task automatic edge_then_settle();
        @(posedge clk);
        #1;
    endtask

    // register-file write scoreboard
    always @(negedge clk) begin
        if (rf_we) begin
            if (rf_q.size() == 0) begin
                total++;
                $display("FAIL rf_unexpected: got write x%0h=%0h expected none", rf_waddr, rf_wdata);
            end else begin
                e = rf_q.pop_front();
                chk("rf_write", {rf_waddr, rf_wdata}, e);
            end
        end
    end

    // store handshake scoreboard
    always @(posedge clk) begin
        if (!rst && st_valid && st_ready) begin
            if (st_q.size() == 0) begin
                total++;
                $display("FAIL st_unexpected: got store %0h=%0h expected none", st_addr, st_data);
            end else chk("store", {st_addr, st_data}, st_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        v;
        logic        d;
        logic [31:0] id;
        logic [31:0] val;
        logic        pop;
    } vec_t;
    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 32'd5, 32'hA, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 32'd6, 32'hB, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 32'd0, 32'hC, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 32'd3, 32'h3, 1'b0};
        for (int i = 4; i < 9; i++) vecs[i] = '{1'b1, 1'b0, 32'd7, 32'h77, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 32'd7, 32'h77, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 32'd0, 32'h0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 32'd9, 32'h99, 1'b1};

        rst = 1'b1; st_ready = 1'b0; w_valid = 1'b0; z4 = '0;
        set_head(1, 1, 0, 0, 32'd4, 32'h44, 0, 0, 0);
        #2;
        chk("pop_in_reset", head_pop, 0);
        edge_then_settle();
        @(negedge clk);
        chk("reset_outputs", {rf_we, st_valid, flush, rf_waddr, rf_wdata}, 0);
        chk("reset_regs", {st_addr, st_data, redirect_pc, epc, retired_count}, 0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            set_head(vecs[i].v, vecs[i].d, 0, 0, vecs[i].id, vecs[i].val, 32'h10 + i, 0, 0);
            #2;
            chk($sformatf("vec%0d_pop", i), head_pop, vecs[i].pop);
            if (vecs[i].pop) begin
                exp_cnt++;
                if (vecs[i].id != 0) rf_q.push_back({vecs[i].id, vecs[i].val});
            end
            edge_then_settle();
            chk($sformatf("vec%0d_count", i), retired_count, 64'(exp_cnt));
            @(negedge clk);
        end

        set_head(1, 1, 1, 0, 32'd2, 32'h22, 32'h20, 32'h1000, 32'hDEAD);
        #2;
        chk("store_issue_pop", head_pop, 0);
        st_q.push_back({32'h1000, 32'hDEAD});
        edge_then_settle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_head(1, 1, 0, 0, 32'd8, 32'h88, 32'h24, 32'h5, 32'h6);
            st_ready = (i == 3);
            #2;
            chk($sformatf("store_hold%0d", i), {st_valid, st_addr, st_data}, {1'b1, 32'h1000, 32'hDEAD});
            chk($sformatf("store_pop%0d", i), head_pop, 64'(i == 3));
        end
        exp_cnt++;
        edge_then_settle();
        @(negedge clk);
        set_head(0, 0, 0, 0, 0, 0, 0, 0, 0);
        st_ready = 1'b0;
        chk("store_done", {st_valid, retired_count}, {1'b0, 32'(exp_cnt)});

        set_head(1, 1, 1, 1, 32'd3, 32'h33, 32'h0040, 32'h2000, 32'hBEEF);
        #2;
        chk("exc_pop", head_pop, 0);
        edge_then_settle();
        chk("exc_regs", {flush, st_valid, epc, redirect_pc}, {2'b10, 32'h0040, 32'h0100});
        @(negedge clk);
        set_head(1, 1, 0, 0, 32'd9, 32'h99, 32'h44, 0, 0);
        #2;
        chk("flush_pop", head_pop, 0);
        edge_then_settle();
        chk("flush_end", {flush, st_valid, retired_count}, {2'b00, 32'(exp_cnt)});
        chk("exc_hold", {epc, redirect_pc}, {32'h0040, 32'h0100});
        @(negedge clk);
        set_head(0, 0, 0, 0, 0, 0, 0, 0, 0);

        set_head(1, 1, 1, 0, 0, 0, 0, 32'h3000, 32'h1234);
        edge_then_settle();
        @(negedge clk);
        set_head(0, 0, 0, 0, 0, 0, 0, 0, 0);
        edge_then_settle();
        @(negedge clk);
        chk("sw2_valid", st_valid, 1);
        rst = 1'b1;
        st_ready = 1'b1;
        #2;
        chk("sw2_rst_pop", head_pop, 0);
        edge_then_settle();
        chk("sw2_rst_out", {st_valid, flush, rf_we, st_addr, st_data}, 0);
        chk("sw2_rst_regs", {epc, redirect_pc, retired_count}, 0);
        @(negedge clk);
        rst = 1'b0;
        st_ready = 1'b0;
        exp_cnt = 0;

        w_valid = 1'b1;
        for (int i = 0; i < 15; i++) @(negedge clk);
        chk("cnt4_15", cnt4, 15);
        @(negedge clk);
        w_valid = 1'b0;
        chk("cnt4_wrap", cnt4, 0);
        @(negedge clk);
        chk("cnt4_hold", cnt4, 0);

        chk("rf_q_drained", rf_q.size(), 0);
        chk("st_q_drained", st_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
